// File: rtl/vga_scanout.sv
// VGA scan-out engine: h/v timing counters, a combinational pixel-fetch request stream and a
// latency-matched delay line that keeps fetched colour aligned with sync and blanking at the pins.
// Optional colour-bar generator (input test_mode) is built when VGA_SCANOUT_TEST_PATTERN_EN is defined.
module vga_scanout #(
  parameter int H_VIS         = 800,
  parameter int H_FP          = 40,
  parameter int H_SYNC        = 128,
  parameter int H_BP          = 88,
  parameter int V_VIS         = 600,
  parameter int V_FP          = 1,
  parameter int V_SYNC        = 4,
  parameter int V_BP          = 23,
  parameter int H_BITS        = 11,
  parameter int V_BITS        = 10,
  parameter bit SYNC_POL      = 1'b0,
  parameter int CHANNEL_BITS  = 4,
  parameter int CHANNEL_COUNT = 4,
  parameter int FETCH_LATENCY = 2,
  parameter int SCALE_SHIFT   = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [CHANNEL_COUNT*CHANNEL_BITS-1:0]   color,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic                                    test_mode,
`endif
  output logic [H_BITS-1:0]                       fetch_x,
  output logic [V_BITS-1:0]                       fetch_y,
  output logic                                    fetch_valid,
  output logic                                    line_start,
  output logic                                    frame_start,
  output logic [CHANNEL_BITS-1:0]                 red,
  output logic [CHANNEL_BITS-1:0]                 green,
  output logic [CHANNEL_BITS-1:0]                 blue,
  output logic                                    h_sync,
  output logic                                    v_sync
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int CW      = CHANNEL_COUNT * CHANNEL_BITS;
  localparam int RGB_W   = 3 * CHANNEL_BITS;

  localparam logic [H_BITS-1:0] H_ZERO   = H_BITS'(0);
  localparam logic [H_BITS-1:0] H_ONE    = H_BITS'(1);
  localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
  localparam logic [H_BITS-1:0] H_VIS_C  = H_BITS'(H_VIS);
  localparam logic [H_BITS-1:0] H_SS_C   = H_BITS'(H_VIS + H_FP);
  localparam logic [H_BITS-1:0] H_SE_C   = H_BITS'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_BITS-1:0] V_ZERO   = V_BITS'(0);
  localparam logic [V_BITS-1:0] V_ONE    = V_BITS'(1);
  localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_VIS_C  = V_BITS'(V_VIS);
  localparam logic [V_BITS-1:0] V_SS_C   = V_BITS'(V_VIS + V_FP);
  localparam logic [V_BITS-1:0] V_SE_C   = V_BITS'(V_VIS + V_FP + V_SYNC);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int DLY_W = 6;
  localparam int BAR_W = H_VIS / 8;
`else
  localparam int DLY_W = 3;
`endif

  logic [H_BITS-1:0]       r_h;
  logic [V_BITS-1:0]       r_v;
  logic                    w_hs_raw;
  logic                    w_vs_raw;
  logic [DLY_W-1:0]        w_dly_in;
  logic [DLY_W-1:0]        w_dly_out;
  logic                    w_d_vis;
  logic                    w_d_hs;
  logic                    w_d_vs;
  logic [RGB_W-1:0]        w_color_rgb;
  logic [RGB_W-1:0]        w_rgb_next;
  logic [CHANNEL_BITS-1:0] r_red;
  logic [CHANNEL_BITS-1:0] r_green;
  logic [CHANNEL_BITS-1:0] r_blue;
  logic                    r_hs;
  logic                    r_vs;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic [2:0]              w_bar_now;
  logic [2:0]              w_d_bar;
  logic [RGB_W-1:0]        w_bar_rgb;

  // The last bar absorbs any remainder because the index saturates at 7.
  function automatic logic [2:0] bar_index(input logic [H_BITS-1:0] h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h >= H_BITS'(i * BAR_W)) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction
`endif

  // Horizontal and vertical position counters; a simultaneous wrap clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= H_ZERO;
      r_v <= V_ZERO;
    end else if (r_h == H_LAST) begin
      r_h <= H_ZERO;
      if (r_v == V_LAST) begin
        r_v <= V_ZERO;
      end else begin
        r_v <= r_v + V_ONE;
      end
    end else begin
      r_h <= r_h + H_ONE;
    end
  end

  assign fetch_x     = r_h >> SCALE_SHIFT;
  assign fetch_y     = r_v >> SCALE_SHIFT;
  assign fetch_valid = (r_h < H_VIS_C) && (r_v < V_VIS_C);
  assign line_start  = (r_h == H_ZERO);
  assign frame_start = (r_h == H_ZERO) && (r_v == V_ZERO);
  assign w_hs_raw    = (r_h >= H_SS_C) && (r_h < H_SE_C);
  assign w_vs_raw    = (r_v >= V_SS_C) && (r_v < V_SE_C);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  assign w_bar_now = bar_index(r_h);
  assign w_dly_in  = {w_bar_now, fetch_valid, w_hs_raw, w_vs_raw};
  assign w_d_bar   = w_dly_out[5:3];
  assign w_bar_rgb = {{CHANNEL_BITS{w_d_bar[2]}}, {CHANNEL_BITS{w_d_bar[1]}}, {CHANNEL_BITS{w_d_bar[0]}}};
`else
  assign w_dly_in  = {fetch_valid, w_hs_raw, w_vs_raw};
`endif

  // Sync and visibility flags are held back by FETCH_LATENCY so they meet the returning colour.
  generate
    if (FETCH_LATENCY == 0) begin : g_no_dly
      assign w_dly_out = w_dly_in;
    end else begin : g_dly
      logic [DLY_W-1:0] r_dly [FETCH_LATENCY];

      // Shift register; stage 0 takes the fresh flags, stages are cleared to blank on reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < FETCH_LATENCY; i++) begin
            r_dly[i] <= {DLY_W{1'b0}};
          end
        end else begin
          r_dly[0] <= w_dly_in;
          for (int i = 1; i < FETCH_LATENCY; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_dly_out = r_dly[FETCH_LATENCY-1];
    end
  endgenerate

  assign w_d_vis     = w_dly_out[2];
  assign w_d_hs      = w_dly_out[1];
  assign w_d_vs      = w_dly_out[0];
  assign w_color_rgb = color[CW-1 -: RGB_W];

  generate
    if (CHANNEL_COUNT > 3) begin : g_extra_channels
      logic w_unused_color;
      assign w_unused_color = ^color[CW-RGB_W-1:0];
    end
  endgenerate

  // Select the colour source for the pixel leaving the delay line; zero while blanked.
  always_comb begin
    w_rgb_next = {RGB_W{1'b0}};
    if (w_d_vis) begin
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      if (test_mode) begin
        w_rgb_next = w_bar_rgb;
      end else begin
        w_rgb_next = w_color_rgb;
      end
`else
      w_rgb_next = w_color_rgb;
`endif
    end else begin
      w_rgb_next = {RGB_W{1'b0}};
    end
  end

  // Pin register stage; sync flags are converted to the configured polarity here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_red   <= {CHANNEL_BITS{1'b0}};
      r_green <= {CHANNEL_BITS{1'b0}};
      r_blue  <= {CHANNEL_BITS{1'b0}};
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
    end else begin
      r_red   <= w_rgb_next[RGB_W-1 -: CHANNEL_BITS];
      r_green <= w_rgb_next[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
      r_blue  <= w_rgb_next[CHANNEL_BITS-1:0];
      r_hs    <= w_d_hs ? SYNC_POL : ~SYNC_POL;
      r_vs    <= w_d_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign red    = r_red;
  assign green  = r_green;
  assign blue   = r_blue;
  assign h_sync = r_hs;
  assign v_sync = r_vs;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a default-timing instance and a small scaled/positive-sync instance,
// each followed cycle by cycle by a scoreboard of expected pin values plus per-scenario checks.
module tb_vga_scanout;

  localparam int A_FL = 2;
  localparam int A_HT = 1056;
  localparam int A_VT = 628;
  localparam int B_FL = 3;
  localparam int B_HT = 24;
  localparam int B_VT = 13;

  logic        clk;
  logic        rst_a, rst_b;
  logic [15:0] color_a, color_b;
  logic        tm_a, tm_b;
  logic [10:0] fetch_x_a, fetch_x_b;
  logic [9:0]  fetch_y_a, fetch_y_b;
  logic        fetch_valid_a, fetch_valid_b;
  logic        line_start_a, line_start_b;
  logic        frame_start_a, frame_start_b;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic        h_sync_a, v_sync_a, h_sync_b, v_sync_b;

  int tests_run = 0;
  int fails = 0;

  int ah, av, bh, bv;
  bit a_en = 1'b0;
  bit b_en = 1'b0;
  logic [13:0] a_q[$];
  logic [13:0] b_q[$];
  logic [10:0] a_fx[$];
  logic [10:0] b_fx[$];

  vga_scanout dut_a (
    .clk(clk), .reset(rst_a), .color(color_a),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .test_mode(tm_a),
`endif
    .fetch_x(fetch_x_a), .fetch_y(fetch_y_a), .fetch_valid(fetch_valid_a),
    .line_start(line_start_a), .frame_start(frame_start_a),
    .red(red_a), .green(green_a), .blue(blue_a), .h_sync(h_sync_a), .v_sync(v_sync_a)
  );

  vga_scanout #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .FETCH_LATENCY(B_FL), .SCALE_SHIFT(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .color(color_b),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .test_mode(tm_b),
`endif
    .fetch_x(fetch_x_b), .fetch_y(fetch_y_b), .fetch_valid(fetch_valid_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .red(red_b), .green(green_b), .blue(blue_b), .h_sync(h_sync_b), .v_sync(v_sync_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {R,G,B,h_sync,v_sync} at the pins for a counter position.
  function automatic logic [13:0] exp_pins(input int h, input int v, input int hv, input int hf,
      input int hsw, input int vv, input int vf, input int vsw, input int sh, input logic pol,
      input logic tm);
    logic [11:0] rgb;
    logic        hs_act, vs_act;
    int          bar;
    logic [2:0]  b3;
    rgb = 12'h000;
    if (h < hv && v < vv) begin
      if (tm) begin
        bar = h / (hv / 8);
        if (bar > 7) bar = 7;
        b3  = 3'(bar);
        rgb = {b3[2] ? 4'hF : 4'h0, b3[1] ? 4'hF : 4'h0, b3[0] ? 4'hF : 4'h0};
      end else begin
        rgb = 12'(h >> sh);
      end
    end
    hs_act = (h >= hv + hf) && (h < hv + hf + hsw);
    vs_act = (v >= vv + vf) && (v < vv + vf + vsw);
    return {rgb, hs_act ? pol : ~pol, vs_act ? pol : ~pol};
  endfunction

  // One pixel clock: advance models, drive the framebuffer colour, score both pin streams.
  task automatic tick();
    logic        pa, pb;
    logic [13:0] e, got;
    logic [10:0] fx;
    pa = rst_a;
    pb = rst_b;
    @(negedge clk);
    if (pa) begin
      ah = 0; av = 0; a_q.delete();
      for (int i = 0; i <= A_FL; i++) a_q.push_back({12'h000, 1'b1, 1'b1});
      a_en = 1'b1;
    end else if (a_en) begin
      ah = ah + 1;
      if (ah == A_HT) begin ah = 0; av = av + 1; if (av == A_VT) av = 0; end
    end
    if (pb) begin
      bh = 0; bv = 0; b_q.delete();
      for (int i = 0; i <= B_FL; i++) b_q.push_back({12'h000, 1'b0, 1'b0});
      b_en = 1'b1;
    end else if (b_en) begin
      bh = bh + 1;
      if (bh == B_HT) begin bh = 0; bv = bv + 1; if (bv == B_VT) bv = 0; end
    end
    a_fx.push_back(fetch_x_a);
    if (a_fx.size() > A_FL) begin fx = a_fx.pop_front(); color_a = {1'b0, fx, 4'h0}; end
    b_fx.push_back(fetch_x_b);
    if (b_fx.size() > B_FL) begin fx = b_fx.pop_front(); color_b = {1'b0, fx, 4'h0}; end
    if (a_en) begin
      a_q.push_back(exp_pins(ah, av, 800, 40, 128, 600, 1, 4, 0, 1'b0, tm_a));
      if (a_q.size() > A_FL + 1) begin
        e = a_q.pop_front();
        got = {red_a, green_a, blue_a, h_sync_a, v_sync_a};
        tests_run++;
        if (got !== e) begin
          fails++;
          $display("FAIL sb_a pins @%0t: got %h expected %h", $time, got, e);
        end
      end
    end
    if (b_en) begin
      b_q.push_back(exp_pins(bh, bv, 16, 2, 3, 8, 1, 2, 1, 1'b1, tm_b));
      if (b_q.size() > B_FL + 1) begin
        e = b_q.pop_front();
        got = {red_b, green_b, blue_b, h_sync_b, v_sync_b};
        tests_run++;
        if (got !== e) begin
          fails++;
          $display("FAIL sb_b pins @%0t: got %h expected %h", $time, got, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({red_a, green_a, blue_a, h_sync_a, v_sync_a} !== {12'h000, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_pins_a: got %h expected %h", {red_a, green_a, blue_a, h_sync_a, v_sync_a},
               {12'h000, 1'b1, 1'b1});
    end
    tests_run++;
    if ({fetch_x_a, fetch_y_a, line_start_a, frame_start_a} !== {11'd0, 10'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_fetch_a: x=%0d y=%0d ls=%b fs=%b expected 0 0 1 1",
               fetch_x_a, fetch_y_a, line_start_a, frame_start_a);
    end
    tests_run++;
    if ({h_sync_b, v_sync_b} !== 2'b00) begin
      fails++;
      $display("FAIL reset_sync_b: got %b expected 00", {h_sync_b, v_sync_b});
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_line();
    int first_fall, second_fall, low_cnt;
    logic prev_hs;
    first_fall = -1; second_fall = -1; low_cnt = 0; prev_hs = h_sync_a;
    for (int n = 1; n <= 1905; n++) begin
      tick();
      if (prev_hs === 1'b1 && h_sync_a === 1'b0) begin
        if (first_fall < 0) first_fall = n;
        else if (second_fall < 0) second_fall = n;
      end
      if (n < 1899 && h_sync_a === 1'b0) low_cnt++;
      prev_hs = h_sync_a;
      if (n == 3 || n == 8 || n == 294 || n == 802 || n == 803) begin
        tests_run++;
        if ({red_a, green_a, blue_a} !== ((n == 803) ? 12'h000 : 12'(n - 3))) begin
          fails++;
          $display("FAIL pixel_%0d: got %h expected %h", n - 3, {red_a, green_a, blue_a},
                   (n == 803) ? 12'h000 : 12'(n - 3));
        end
      end
      if (n == 1056) begin
        tests_run++;
        if ({line_start_a, frame_start_a, fetch_y_a} !== {1'b1, 1'b0, 10'd1}) begin
          fails++;
          $display("FAIL line_wrap: ls=%b fs=%b y=%0d expected 1 0 1", line_start_a, frame_start_a,
                   fetch_y_a);
        end
      end
    end
    tests_run++;
    if (first_fall != 843) begin
      fails++;
      $display("FAIL hsync_start: got %0d expected 843", first_fall);
    end
    tests_run++;
    if (low_cnt != 128) begin
      fails++;
      $display("FAIL hsync_width: got %0d expected 128", low_cnt);
    end
    tests_run++;
    if (second_fall - first_fall != 1056) begin
      fails++;
      $display("FAIL hsync_period: got %0d expected 1056", second_fall - first_fall);
    end
  endtask

  task automatic test_scale_pol();
    int exp_x[5] = '{0, 0, 1, 1, 2};
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int n = 0; n <= 25; n++) begin
      if (n > 0) tick();
      if (n < 5) begin
        tests_run++;
        if (fetch_x_b !== 11'(exp_x[n])) begin
          fails++;
          $display("FAIL scale_x_%0d: got %0d expected %0d", n, fetch_x_b, exp_x[n]);
        end
      end
      if (n == 21 || n == 22 || n == 24 || n == 25) begin
        tests_run++;
        if (h_sync_b !== ((n == 22 || n == 24) ? 1'b1 : 1'b0)) begin
          fails++;
          $display("FAIL hsync_pol_%0d: got %b expected %b", n, h_sync_b, (n == 22 || n == 24));
        end
      end
    end
  endtask

  task automatic test_frame();
    int fs_cnt, ls_cnt, vs_rise, vs_hi;
    logic prev_vs;
    fs_cnt = 0; ls_cnt = 0; vs_rise = -1; vs_hi = 0;
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    prev_vs = v_sync_b;
    for (int n = 0; n < 3 * B_HT * B_VT; n++) begin
      if (n > 0) tick();
      if (frame_start_b === 1'b1) fs_cnt++;
      if (line_start_b === 1'b1) ls_cnt++;
      if (prev_vs === 1'b0 && v_sync_b === 1'b1 && vs_rise < 0) vs_rise = n;
      if (n < 312 && v_sync_b === 1'b1) vs_hi++;
      prev_vs = v_sync_b;
    end
    tests_run++;
    if (fs_cnt != 3) begin fails++; $display("FAIL frame_pulses: got %0d expected 3", fs_cnt); end
    tests_run++;
    if (ls_cnt != 39) begin fails++; $display("FAIL line_pulses: got %0d expected 39", ls_cnt); end
    tests_run++;
    if (vs_rise != 220) begin fails++; $display("FAIL vsync_start: got %0d expected 220", vs_rise); end
    tests_run++;
    if (vs_hi != 48) begin fails++; $display("FAIL vsync_width: got %0d expected 48", vs_hi); end
  endtask

  task automatic test_midreset();
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    repeat (5 * B_HT + 10) tick();
    tests_run++;
    if ({fetch_x_b, fetch_y_b} !== {11'd5, 10'd2}) begin
      fails++;
      $display("FAIL mid_position: x=%0d y=%0d expected 5 2", fetch_x_b, fetch_y_b);
    end
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    tests_run++;
    if ({fetch_x_b, fetch_y_b, frame_start_b} !== {11'd0, 10'd0, 1'b1}) begin
      fails++;
      $display("FAIL mid_reset_ctr: x=%0d y=%0d fs=%b expected 0 0 1", fetch_x_b, fetch_y_b,
               frame_start_b);
    end
    tests_run++;
    if ({red_b, green_b, blue_b, h_sync_b, v_sync_b} !== 14'h0) begin
      fails++;
      $display("FAIL mid_reset_pins: got %h expected 0000", {red_b, green_b, blue_b, h_sync_b, v_sync_b});
    end
    repeat (40) tick();
  endtask

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [11:0] e;
    tm_a = 1'b1; rst_a = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    for (int n = 1; n <= 805; n++) begin
      tick();
      if (n == 53 || n == 102 || n == 103 || n == 153 || n == 453 || n == 753 || n == 802) begin
        case (n)
          53, 102:  e = 12'h000;
          103, 153: e = 12'h00F;
          453:      e = 12'hF00;
          default:  e = 12'hFFF;
        endcase
        tests_run++;
        if ({red_a, green_a, blue_a} !== e) begin
          fails++;
          $display("FAIL bar_pixel_%0d: got %h expected %h", n - 3, {red_a, green_a, blue_a}, e);
        end
      end
    end
    tm_a = 1'b0; rst_a = 1'b1; tick(); rst_a = 1'b0;
    repeat (10) tick();
  endtask
`endif

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    color_a = 16'h0000; color_b = 16'h0000;
    tm_a = 1'b0; tm_b = 1'b0;
    test_reset();
    test_line();
    test_scale_pol();
    test_frame();
    test_midreset();
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
